// File: rtl/sandpiper_frame_writer_if.sv
// sandpiper_frame_writer_if
//   Frame request channel between one requester and the Sandpiper frame writer.
//   A request transfers on a sys_clk edge where valid and ready are both high.
//   Signals:
//     valid   requester -> writer  frame request pending
//     ready   writer -> requester  request accepted this cycle
//     value   requester -> writer  nibble k selects the glyph for character k
//     dp      requester -> writer  bit k lights the decimal point of character k
//     bright  requester -> writer  brightness applied to every character
//   Modports: master (requester side), slave (frame writer side).
interface sandpiper_frame_writer_if #(
  parameter int VALUE_W  = 32,
  parameter int DP_W     = 8,
  parameter int BRIGHT_W = 8
);
  logic                valid;
  logic                ready;
  logic [VALUE_W-1:0]  value;
  logic [DP_W-1:0]     dp;
  logic [BRIGHT_W-1:0] bright;

  modport master (output valid, output value, output dp, output bright, input ready);
  modport slave  (input valid, input value, input dp, input bright, output ready);
endinterface

// File: rtl/sandpiper_frame_writer.sv
// sandpiper_frame_writer
//   Sequencer/arbiter in front of the Sandpiper 7-seg driver. Two requesters
//   submit whole-frame writes; the winner (round robin) has all CAN_CT
//   characters written into the driver buffer, one commit_char strobe each.
//   Optional feature macro: LEADING_ZERO_BLANK_EN (blank glyphs above the
//   highest nonzero nibble; DP bits still shown, char 0 always drawn).
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   req0, req1         frame request channels (slave modport)
//   busy               frame write in progress
//   frame_done         1-cycle pulse after the last strobe has been released
//   grant_id           requester owning the current/last frame
//   commit_char        driver commit strobe (driver samples on its rising edge)
//   char_selected      driver character address
//   segments           driver segment pattern {DP,G,F,E,D,C,B,A}
//   char_brightness    driver brightness
//
// State   | meaning
// IDLE    | arbitrate; ready asserted to the chosen requester
// SETUP   | present character idx on the data outputs, strobe low
// STROBE  | commit_char high for STROBE_CYC cycles
// RELEASE | commit_char low for STROBE_CYC cycles, then next char or DONE
// DONE    | pulse frame_done, return to IDLE
module sandpiper_frame_writer #(
  parameter int CAN_CT     = 8,
  parameter int SEG_CT     = 8,
  parameter int DIMMING_W  = 8,
  parameter int STROBE_CYC = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  sandpiper_frame_writer_if.slave     req0,
  sandpiper_frame_writer_if.slave     req1,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        grant_id,
  output logic                        commit_char,
  output logic [$clog2(CAN_CT)-1:0]   char_selected,
  output logic [SEG_CT-1:0]           segments,
  output logic [DIMMING_W-1:0]        char_brightness
);
  localparam int IDX_W = $clog2(CAN_CT);
  localparam int TMR_W = $clog2(STROBE_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STROBE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CAN_CT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    last_grant_q;
  logic                    gnt0, gnt1;
  logic [4*CAN_CT-1:0]     value_q;
  logic [CAN_CT-1:0]       dp_q;
  logic [DIMMING_W-1:0]    bright_q;
  logic [3:0]              nibble;
  logic [SEG_CT-1:0]       seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign nibble = value_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msn;

  // Highest nonzero nibble; stays 0 for an all-zero value so char 0 shows "0".
  always_comb begin
    msn = '0;
    for (int k = 0; k < CAN_CT; k++) begin
      if (value_q[4*k +: 4] != 4'h0) msn = IDX_W'(k);
    end
  end

  always_comb begin
    seg_d = '0;
    seg_d[SEG_CT-1] = dp_q[idx_q];
    if (idx_q <= msn) seg_d[6:0] = hex7(nibble);
  end
`else
  always_comb begin
    seg_d = '0;
    seg_d[SEG_CT-1] = dp_q[idx_q];
    seg_d[6:0] = hex7(nibble);
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On contention the port that did not win last time is served.
        if (req0.valid && req1.valid) begin
          if (last_grant_q) gnt0 = 1'b1;
          else              gnt1 = 1'b1;
        end else if (req0.valid) begin
          gnt0 = 1'b1;
        end else if (req1.valid) begin
          gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          state_d = S_SETUP;
          idx_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        tmr_d   = TMR_LOAD;
      end
      S_STROBE: begin
        if (tmr_q == '0) begin
          state_d = S_RELEASE;
          tmr_d   = TMR_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_RELEASE: begin
        if (tmr_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req0.ready = gnt0;
  assign req1.ready = gnt1;

  // Driver-facing outputs are registered from the current state, so they
  // trail the FSM by one cycle: commit rises two edges after the accept.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      tmr_q           <= '0;
      last_grant_q    <= 1'b1;
      value_q         <= '0;
      dp_q            <= '0;
      bright_q        <= '0;
      grant_id        <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      commit_char     <= 1'b0;
      char_selected   <= '0;
      segments        <= '0;
      char_brightness <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      busy        <= (state_d != S_IDLE);
      frame_done  <= (state_q == S_DONE);
      commit_char <= (state_q == S_STROBE);
      if (gnt0) begin
        value_q  <= req0.value;
        dp_q     <= req0.dp;
        bright_q <= req0.bright;
      end else if (gnt1) begin
        value_q  <= req1.value;
        dp_q     <= req1.dp;
        bright_q <= req1.bright;
      end
      if (gnt0 || gnt1) begin
        grant_id     <= gnt1;
        last_grant_q <= gnt1;
      end
      if (state_q == S_SETUP) begin
        char_selected   <= idx_q;
        segments        <= seg_d;
        char_brightness <= bright_q;
      end
    end
  end
endmodule

// File: tb/tb_sandpiper_frame_writer.sv
module tb_sandpiper_frame_writer;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       busy, frame_done, grant_id, commit_char;
  logic [2:0] char_selected;
  logic [7:0] segments, char_brightness;

  int errors = 0;
  int checks = 0;

  sandpiper_frame_writer_if req0_if ();
  sandpiper_frame_writer_if req1_if ();

  sandpiper_frame_writer dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .req0            (req0_if),
    .req1            (req1_if),
    .busy            (busy),
    .frame_done      (frame_done),
    .grant_id        (grant_id),
    .commit_char     (commit_char),
    .char_selected   (char_selected),
    .segments        (segments),
    .char_brightness (char_brightness)
  );

  always #5 sys_clk = ~sys_clk;

  // Capture of one frame as seen at each commit_char rising edge.
  logic [7:0] cap_seg [8];
  logic [7:0] cap_br  [8];
  logic [2:0] cap_sel [8];
  int n_strobes, done_cyc, first_commit, ready_leak;

  // Expected glyphs, value[3:0] -> char 0.
  logic [7:0] exp_f1 [8] = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h4F, 8'h5B, 8'h06, 8'h3F}; // 0x0123ABCD
  logic [7:0] exp_f2 [8] = '{8'hF1, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'hF1}; // 0xFFFFFFFF dp 0x81
`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] exp_f3 [8] = '{8'h5B, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}; // 0x42 dp 0x80
`else
  logic [7:0] exp_f3 [8] = '{8'h5B, 8'h66, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hBF};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; returns at the
  // negedge where frame_done is seen (or after a bounded number of cycles).
  task automatic run_frame();
    logic prev;
    n_strobes = 0; done_cyc = -1; first_commit = -1; ready_leak = 0;
    prev = commit_char;
    for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (commit_char && !prev) begin
        if (n_strobes < 8) begin
          cap_seg[n_strobes] = segments;
          cap_br[n_strobes]  = char_brightness;
          cap_sel[n_strobes] = char_selected;
        end
        if (first_commit < 0) first_commit = k;
        n_strobes++;
      end
      prev = commit_char;
      if (busy && (req0_if.ready || req1_if.ready)) ready_leak++;
      if (frame_done) done_cyc = k;
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp_seg [8], input logic [7:0] exp_br);
    chk({name, "_strobes"}, 32'(n_strobes), 32'd8);
    chk({name, "_commit_lat"}, 32'(first_commit), 32'd2);
    chk({name, "_done_lat"}, 32'(done_cyc), 32'd41);
    chk({name, "_ready_while_busy"}, 32'(ready_leak), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_sel%0d", name, i), 32'(cap_sel[i]), 32'(i));
      chk($sformatf("%s_seg%0d", name, i), 32'(cap_seg[i]), 32'(exp_seg[i]));
      chk($sformatf("%s_br%0d", name, i), 32'(cap_br[i]), 32'(exp_br));
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    req0_if.valid = 1'b0; req0_if.value = '0; req0_if.dp = '0; req0_if.bright = '0;
    req1_if.valid = 1'b0; req1_if.value = '0; req1_if.dp = '0; req1_if.bright = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_commit", 32'(commit_char), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_sel", 32'(char_selected), 32'd0);
    chk("rst_seg", 32'(segments), 32'd0);
    chk("rst_br", 32'(char_brightness), 32'd0);
    sys_rst = 1'b0;

    // Contention right after reset: port 0 first
    req0_if.valid = 1'b1; req0_if.value = 32'h0123ABCD; req0_if.dp = 8'h00; req0_if.bright = 8'h80;
    req1_if.valid = 1'b1; req1_if.value = 32'hFFFFFFFF; req1_if.dp = 8'h81; req1_if.bright = 8'h3C;
    #1;
    chk("c1_ready0", 32'(req0_if.ready), 32'd1);
    chk("c1_ready1", 32'(req1_if.ready), 32'd0);
    @(posedge sys_clk); @(negedge sys_clk);
    req0_if.valid = 1'b0;
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_grant", 32'(grant_id), 32'd0);
    run_frame();
    check_frame("f1", exp_f1, 8'h80);
    chk("f1_busy_after", 32'(busy), 32'd0);

    // Port 1 held valid throughout; now contend again with port 0
    req0_if.valid = 1'b1; req0_if.value = 32'h00000042; req0_if.dp = 8'h80; req0_if.bright = 8'h11;
    #1;
    chk("c2_ready1", 32'(req1_if.ready), 32'd1);
    chk("c2_ready0", 32'(req0_if.ready), 32'd0);
    @(posedge sys_clk); @(negedge sys_clk);
    req1_if.valid = 1'b0;
    chk("f2_grant", 32'(grant_id), 32'd1);
    run_frame();
    check_frame("f2", exp_f2, 8'h3C);

    // Port 0 waited the whole frame; accepted in the first idle cycle
    chk("f3_ready0_first_idle", 32'(req0_if.ready), 32'd1);
    @(posedge sys_clk); @(negedge sys_clk);
    req0_if.valid = 1'b0;
    chk("f3_grant", 32'(grant_id), 32'd0);
    run_frame();
    check_frame("f3", exp_f3, 8'h11);

    // Reset during the strobe of character 3
    req0_if.valid = 1'b1; req0_if.value = 32'h0; req0_if.dp = 8'h00; req0_if.bright = 8'h22;
    @(posedge sys_clk); @(negedge sys_clk);
    req0_if.valid = 1'b0;
    repeat (17) begin
      @(posedge sys_clk); @(negedge sys_clk);
    end
    chk("r_pre_commit", 32'(commit_char), 32'd1);
    chk("r_pre_sel", 32'(char_selected), 32'd3);
    req1_if.valid = 1'b1;
    #1;
    chk("r_pre_ready1", 32'(req1_if.ready), 32'd0);
    sys_rst = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("r_commit", 32'(commit_char), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ready1", 32'(req1_if.ready), 32'd1);
    chk("r_sel", 32'(char_selected), 32'd0);
    sys_rst = 1'b0;
    req1_if.valid = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("r_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
